// File: rtl/comb_unrank_pkg.sv
// Shared definitions for the combination unranker: default widths, FSM state
// encoding, and a Pascal-recurrence binomial that folds to constants at elaboration.
package comb_pkg;

  localparam int WN_DEF = 4;
  localparam int WR_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SCAN,
    EMIT,
    DONE
  } state_t;

  // Builds Pascal's triangle row by row; C(n,m) is 0 for m>n because those
  // entries of the row are never reached. Valid for n < 64.
  function automatic int unsigned binomial(input int unsigned n, input int unsigned m);
    int unsigned row [64];
    for (int unsigned j = 0; j < 64; j++) row[j] = (j == 0) ? 1 : 0;
    for (int unsigned i = 1; i <= n && i < 64; i++) begin
      for (int unsigned j = i; j > 0; j--) row[j] = row[j] + row[j-1];
    end
    return (m < 64) ? row[m] : 0;
  endfunction

endpackage

// File: rtl/comb_unrank_if.sv
// Host/consumer bundle for comb_unrank. The optional mask output exists only
// when COMB_UNRANK_MASK_EN is defined.
interface comb_unrank_if
  import comb_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WR = WR_DEF
) ();

  logic          start;
  logic [WN-1:0] N;
  logic [WN-1:0] K;
  logic [WR-1:0] rank;
  logic          busy;
  logic          elem_valid;
  logic [WN-1:0] elem;
  logic          elem_last;
  logic          elem_ready;
  logic          done;
  logic          err;
`ifdef COMB_UNRANK_MASK_EN
  logic [2**WN-1:0] mask;
`endif

  modport master (
    output start, N, K, rank, elem_ready,
    input  busy, elem_valid, elem, elem_last, done, err
`ifdef COMB_UNRANK_MASK_EN
    , input mask
`endif
  );

  modport slave (
    input  start, N, K, rank, elem_ready,
    output busy, elem_valid, elem, elem_last, done, err
`ifdef COMB_UNRANK_MASK_EN
    , output mask
`endif
  );

endinterface

// File: rtl/comb_unrank_binom_lut.sv
// Combinational C(n,m) lookup; every table entry is an elaboration-time constant.
module binom_lut
  import comb_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WR = WR_DEF
) (
  input  logic [WN-1:0] n,
  input  logic [WN-1:0] m,
  output logic [WR-1:0] c
);

  localparam int SZ = 2**WN;

  logic [WR-1:0] lut [SZ][SZ];

  for (genvar i = 0; i < SZ; i++) begin : g_n
    for (genvar j = 0; j < SZ; j++) begin : g_m
      assign lut[i][j] = WR'(binomial(i, j));
    end
  end

  assign c = lut[n][m];

endmodule

// File: rtl/comb_unrank.sv
// Combination unranker: streams the rank-th K-subset of {0..N-1} in lexicographic
// order, smallest element first. Optional element mask under COMB_UNRANK_MASK_EN.
module comb_unrank
  import comb_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WR = WR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  comb_unrank_if.slave bus
);

  localparam logic [WN-1:0] ONE_N = WN'(1);

  state_t        state, next_state;
  logic [WN-1:0] n_r, k_r, x_r;
  logic [WR-1:0] r_r;
  logic          busy_r, done_r, err_r;
  logic [WR-1:0] total_c, step_c;
  logic [WN-1:0] step_n, step_m;
  logic          check_bad, take;
`ifdef COMB_UNRANK_MASK_EN
  logic [2**WN-1:0] mask_r;
`endif

  // Candidate x is chosen when the rank falls inside the block of subsets that
  // start with x: C(remaining elements after x, remaining picks after x).
  assign step_n = n_r - x_r - ONE_N;
  assign step_m = k_r - ONE_N;

  binom_lut #(.WN(WN), .WR(WR)) u_total (.n(n_r),    .m(k_r),    .c(total_c));
  binom_lut #(.WN(WN), .WR(WR)) u_step  (.n(step_n), .m(step_m), .c(step_c));

  assign check_bad = (k_r > n_r) || (r_r >= total_c);
  assign take      = (r_r < step_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = CHECK;
      CHECK:   next_state = (check_bad || k_r == '0) ? DONE : SCAN;
      SCAN:    if (take) next_state = EMIT;
      EMIT:    if (bus.elem_ready) next_state = (k_r == ONE_N) ? DONE : SCAN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_r    <= '0;
      k_r    <= '0;
      x_r    <= '0;
      r_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
`ifdef COMB_UNRANK_MASK_EN
      mask_r <= '0;
`endif
    end else begin
      busy_r <= (next_state != IDLE);
      done_r <= (next_state == DONE);
      err_r  <= (state == CHECK) && check_bad;
      case (state)
        IDLE: if (bus.start) begin
          n_r <= bus.N;
          k_r <= bus.K;
          r_r <= bus.rank;
          x_r <= '0;
`ifdef COMB_UNRANK_MASK_EN
          mask_r <= '0;
`endif
        end
        SCAN: if (!take) begin
          r_r <= r_r - step_c;
          x_r <= x_r + ONE_N;
        end
        EMIT: if (bus.elem_ready) begin
          k_r <= k_r - ONE_N;
          x_r <= x_r + ONE_N;
`ifdef COMB_UNRANK_MASK_EN
          mask_r[x_r] <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.elem_valid = (state == EMIT);
  assign bus.elem       = bus.elem_valid ? x_r : '0;
  assign bus.elem_last  = bus.elem_valid && (k_r == ONE_N);
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
`ifdef COMB_UNRANK_MASK_EN
  assign bus.mask       = mask_r;
`endif

endmodule

// File: tb/tb_comb_unrank.sv
// Self-checking bench for comb_unrank: directed and random requests compared
// against a next-combination enumeration model, plus backpressure and reset cases.
`timescale 1ns/1ps
module tb_comb_unrank;
  import comb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  comb_unrank_if bus ();
  comb_unrank dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk r steps through the lexicographic list of K-subsets; running off the
  // end of the list means the rank is out of range.
  function automatic void model(input int n, input int k, input int r,
                                output bit e, output int q[$]);
    int c[16];
    int i;
    q.delete();
    e = 1'b0;
    if (k > n) begin e = 1'b1; return; end
    for (int j = 0; j < k; j++) c[j] = j;
    for (int step = 0; step < r; step++) begin
      i = k - 1;
      while (i >= 0 && c[i] == n - k + i) i--;
      if (i < 0) begin e = 1'b1; return; end
      c[i]++;
      for (int j = i + 1; j < k; j++) c[j] = c[j-1] + 1;
    end
    for (int j = 0; j < k; j++) q.push_back(c[j]);
  endfunction

  function automatic int choose(input int n, input int k);
    int c = 1;
    if (k > n) return 0;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  task automatic run_req(input int n, input int k, input int r, input int stall, input string tag);
    bit exp_err;
    int exp_q[$];
    int got_q[$];
    int wait_cnt = 0;
    int held = 0;
    bit holding = 1'b0;
    int valid_cycles = 0;
    bit finished = 1'b0;
    int exp_mask = 0;
    model(n, k, r, exp_err, exp_q);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.N          = n[3:0];
    bus.K          = k[3:0];
    bus.rank       = r[14:0];
    bus.elem_ready = (stall == 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.N     = '0;
    bus.K     = '0;
    bus.rank  = '0;
    check({tag, " busy"}, bus.busy, 1);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (bus.done) begin
        finished = 1'b1;
        check({tag, " err"}, bus.err, exp_err);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
          check($sformatf("%s elem%0d", tag, i), got_q[i], exp_q[i]);
        if (exp_err) check({tag, " valid cycles"}, valid_cycles, 0);
`ifdef COMB_UNRANK_MASK_EN
        foreach (exp_q[i]) exp_mask |= (1 << exp_q[i]);
        check({tag, " mask"}, bus.mask, exp_mask);
`endif
      end else if (bus.elem_valid) begin
        valid_cycles++;
        if (holding) check({tag, " held"}, bus.elem, held);
        if (wait_cnt < stall) begin
          bus.elem_ready = 1'b0;
          wait_cnt++;
          if (!holding) held = int'(bus.elem);
          holding = 1'b1;
        end else begin
          bus.elem_ready = 1'b1;
          got_q.push_back(int'(bus.elem));
          check({tag, " last"}, bus.elem_last, got_q.size() == exp_q.size());
          wait_cnt = 0;
          holding  = 1'b0;
        end
      end else begin
        bus.elem_ready = (stall == 0);
      end
      @(negedge clk);
    end
    check({tag, " finished"}, finished, 1);
    check({tag, " done pulse"}, bus.done, 0);
    check({tag, " busy low"}, bus.busy, 0);
  endtask

  initial begin
    bit seen;
    int n, k, r, total;
    bus.start      = 1'b0;
    bus.N          = '0;
    bus.K          = '0;
    bus.rank       = '0;
    bus.elem_ready = 1'b0;

    #1;
    check("reset busy", bus.busy, 0);
    check("reset valid", bus.elem_valid, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_req(5, 2, 0, 0, "n5k2r0");
    run_req(5, 2, 4, 0, "n5k2r4");
    run_req(5, 2, 9, 0, "n5k2r9");
    run_req(5, 2, 10, 0, "n5k2r10 err");
    run_req(5, 6, 0, 0, "k>n err");
    run_req(15, 7, 6434, 0, "n15k7 max");
    run_req(15, 7, 6435, 0, "n15k7 over");
    run_req(4, 3, 2, 3, "n4k3 stall");
    run_req(4, 0, 0, 0, "k0");
    run_req(4, 0, 1, 0, "k0 r1 err");
    run_req(15, 15, 0, 1, "n15k15");
    run_req(15, 1, 14, 0, "n15k1 last");

    // Reset while an element is waiting for the consumer.
    @(negedge clk);
    bus.start = 1'b1; bus.N = 4'd6; bus.K = 4'd3; bus.rank = 15'd7;
    bus.elem_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      if (bus.elem_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst emit reached", seen, 1);
    rst = 1'b0;
    #1;
    check("rst valid", bus.elem_valid, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst elem", bus.elem, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst no done", bus.done, 0);
    end
    rst = 1'b1;
    run_req(6, 3, 7, 0, "after rst");

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(0, 15);
      k = $urandom_range(0, n + 1);
      total = choose(n, k);
      if ($urandom_range(0, 7) == 0 || total == 0) r = total + $urandom_range(0, 2);
      else r = $urandom_range(0, total - 1);
      run_req(n, k, r, $urandom_range(0, 2), $sformatf("rand%0d n%0d k%0d r%0d", t, n, k, r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comb_unrank.md
Name: comb_unrank

Overview:
- Combination unranker: given N, K and a 15-bit rank r, streams the r-th K-subset of {0..N-1} in lexicographic order, one element per handshake, smallest element first.
- Inverse direction of the combination-counting datapath: that block enumerates and counts subsets; this one turns a count index back into a subset.
- Sits between the control host (start/operands) and any element consumer (valid/ready).

Parameters:
- WN, 4, width of N, K and element values; N,K <= 2**WN-1.
- WR, 15, width of rank and binomial values; must hold C(15,7)=6435.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request; sampled only in IDLE.
- N  in  WN  set size; captured on start.
- K  in  WN  subset size; captured on start.
- rank  in  WR  requested index, 0-based; captured on start.
- busy  out  1  high from the cycle after start until DONE exits.
- elem_valid  out  1  element available.
- elem  out  WN  element value.
- elem_last  out  1  qualifies the final element of the subset.
- elem_ready  in  1  consumer accepts when elem_valid & elem_ready.
- done  out  1  one-cycle pulse at end of request.
- err  out  1  valid with done: K>N or rank>=C(N,K); no elements emitted.

Behaviour:
- Reset (async, rst=0): state=IDLE, all outputs 0, internal registers n_r, k_r, r_r, x_r cleared.
- Binomial C(n,m): combinational, WR bits; C(n,0)=1, C(n,m)=0 if m>n.
- IDLE: on start, latch N, K and rank into n_r, k_r and r_r; x_r<=0; go to CHECK. A start during any other state is ignored.
- CHECK (1 cycle): if K>N or rank>=C(N,K), set err, go to DONE. Else if k_r==0, go to DONE (empty subset, no elements). Else go to SCAN.
- SCAN (one candidate x_r per cycle): c=C(n_r-1-x_r, k_r-1).
  - If r_r<c: element x_r selected; go to EMIT.
  - Else: r_r<=r_r-c; x_r<=x_r+1; stay in SCAN.
- EMIT: elem_valid=1, elem=x_r, elem_last=(k_r==1); elem/elem_last held stable while elem_ready=0.
  - On handshake: k_r<=k_r-1, x_r<=x_r+1; if k_r==1 go to DONE, else go to SCAN.
- DONE (1 cycle): done=1, err as computed, busy=0 next cycle; return to IDLE.
- Guarantees:
  - Valid rank never lets x_r exceed n_r-1.
  - Subtraction never underflows.
  - No wrap-around in x_r.
- Latency: start -> first elem_valid = 2 + (candidates skipped before first element) cycles. Worst case per request is <= N+K+3 cycles without backpressure.
- Reset mid-operation: aborts immediately with no done pulse; elem_valid drops asynchronously.
- err and done are registered outputs; elem_valid is a registered state decode.

Optional Feature:
- Macro COMB_UNRANK_MASK_EN.
- Defined: extra output mask [2**WN-1:0] is cleared on start and has bit x set at each element handshake. It is valid and held from done until the next start. err leaves mask all-zero.
- Undefined: port and logic are absent; stream behaviour is identical.

Decomposition:
- Package comb_pkg: WN/WR defaults, state enum {IDLE, CHECK, SCAN, EMIT, DONE}, binomial function (Pascal recurrence, constant-foldable).
- Sub-module binom_lut: combinational (n,m) -> C(n,m), WR bits. It is instantiated twice: one total-count lookup for CHECK and one step lookup for SCAN.

Test Plan:
- N=5,K=2,rank=0, ready=1 -> elems 0,1; last on 1; done=1, err=0.
- N=5,K=2,rank=4 -> elems 1,2; rank=9 -> elems 3,4.
- N=5,K=2,rank=10 -> done with err=1, zero elem_valid cycles; K=6,N=5 -> err=1.
- N=15,K=7,rank=6434 -> elems 8..14; with MASK_EN, mask=16'h7F00.
- N=4,K=3,rank=2, elem_ready low 3 cycles each element -> elems 0,2,3 held stable; no drop or duplicate. K=0 -> done, no elements, err=0.
- Assert rst=0 during EMIT of N=6,K=3 -> outputs 0 immediately, no done. A new start after release runs cleanly.
